// File: rtl/seq_detect_param_if.sv
// Sample/pattern/counter bundle for seq_detect_param.
// SEQ_DETECT_MASK_EN adds the pattern mask input.
interface seq_detect_param_if #(
    parameter int unsigned PAT_W = 4,
    parameter int unsigned CNT_W = 8
);
    logic             x;
    logic             x_valid;
    logic             overlap;
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0] pat_mask_in;
`endif
    logic             cnt_clr;
    logic             F;
    logic [CNT_W-1:0] match_cnt;
    logic             armed;

    modport master (
        output x,
        output x_valid,
        output overlap,
        output pat_load,
        output pat_in,
`ifdef SEQ_DETECT_MASK_EN
        output pat_mask_in,
`endif
        output cnt_clr,
        input  F,
        input  match_cnt,
        input  armed
    );

    modport slave (
        input  x,
        input  x_valid,
        input  overlap,
        input  pat_load,
        input  pat_in,
`ifdef SEQ_DETECT_MASK_EN
        input  pat_mask_in,
`endif
        input  cnt_clr,
        output F,
        output match_cnt,
        output armed
    );
endinterface

// File: rtl/seq_detect_param.sv
// Parametrised serial sequence detector with saturating match count.
// Define SEQ_DETECT_MASK_EN for per-bit don't-care pattern masking.
module seq_detect_param #(
    parameter int unsigned PAT_W     = 4,
    parameter int unsigned CNT_W     = 8,
    parameter logic [31:0] RESET_PAT = 32'b1011
) (
    input logic               clk,
    input logic               rst,
    seq_detect_param_if.slave bus
);
    localparam int unsigned FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [FW-1:0] LAST = FW'(PAT_W - 1);
    localparam logic [PAT_W-1:0] RST_PAT = RESET_PAT[PAT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [PAT_W-1:0] pat;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    logic             f_q;
    logic [CNT_W-1:0] cnt_q;
    logic             armed_q;
`ifdef SEQ_DETECT_MASK_EN
    logic [PAT_W-1:0] pat_mask;
`endif

    logic [PAT_W-1:0] cand;
    logic             match;
    logic             hit;
    logic [PAT_W-1:0] hist_nxt;
    logic [FW-1:0]    fill_nxt;

    // Candidate window, hit decision and next history/fill
    always_comb begin
        cand = {hist[PAT_W-2:0], bus.x};
`ifdef SEQ_DETECT_MASK_EN
        match = ((cand ^ pat) & pat_mask) == '0;
`else
        match = (cand == pat);
`endif
        hit = bus.x_valid && !bus.pat_load
              && (fill >= LAST) && match;
        hist_nxt = hist;
        fill_nxt = fill;
        if (bus.pat_load) begin
            hist_nxt = '0;
            fill_nxt = '0;
        end else if (bus.x_valid) begin
            if (hit && !bus.overlap) begin
                hist_nxt = '0;
                fill_nxt = '0;
            end else begin
                hist_nxt = cand;
                fill_nxt = (fill == FULL) ? FULL : fill + 1'b1;
            end
        end
    end

    // Registered state, match pulse, counter and armed flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            pat     <= RST_PAT;
`ifdef SEQ_DETECT_MASK_EN
            pat_mask <= '1;
`endif
            hist    <= '0;
            fill    <= '0;
            f_q     <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            if (bus.pat_load) begin
                pat <= bus.pat_in;
`ifdef SEQ_DETECT_MASK_EN
                pat_mask <= bus.pat_mask_in;
`endif
            end
            hist    <= hist_nxt;
            fill    <= fill_nxt;
            f_q     <= hit;
            armed_q <= (fill_nxt == FULL);
            if (bus.cnt_clr) begin
                cnt_q <= '0;
            end else if (hit && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign bus.F         = f_q;
    assign bus.match_cnt = cnt_q;
    assign bus.armed     = armed_q;
endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench for seq_detect_param (PAT_W=4, CNT_W=2).
// Model keeps the accepted bits as a queue and matches the tail.
module tb_seq_detect_param;
    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    seq_detect_param_if #(.PAT_W(4), .CNT_W(2)) bif ();

    seq_detect_param #(
        .PAT_W(4),
        .CNT_W(2),
        .RESET_PAT(32'b1011)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bif.slave)
    );

    typedef struct packed {
        logic       f;
        logic [1:0] cnt;
        logic       armed;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    bit   mq[$];
    logic [3:0] m_pat = 4'b1011;
    logic [3:0] m_mask = 4'b1111;
    logic [1:0] m_cnt = 2'd0;
    logic       ovl = 1'b1;
    logic [3:0] mski = 4'b1111;
    int checks = 0;
    int errors = 0;
    int f_seen = 0;

    // Compare every driven cycle against the model one edge later
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            if (bif.F !== mon_e.f || bif.match_cnt !== mon_e.cnt
                || bif.armed !== mon_e.armed) begin
                errors++;
                $display("FAIL scoreboard t=%0t got F=%b cnt=%0d armed=%b required F=%b cnt=%0d armed=%b",
                         $time, bif.F, bif.match_cnt, bif.armed,
                         mon_e.f, mon_e.cnt, mon_e.armed);
            end
            if (bif.F === 1'b1) f_seen++;
        end
    end

    task automatic step(input logic r, input logic v, input logic xb,
                        input logic ld, input logic [3:0] pi,
                        input logic clr);
        logic       hit;
        logic [3:0] w;
        exp_t       e;
        @(negedge clk);
        rst          = r;
        bif.x        = xb;
        bif.x_valid  = v;
        bif.overlap  = ovl;
        bif.pat_load = ld;
        bif.pat_in   = pi;
        bif.cnt_clr  = clr;
`ifdef SEQ_DETECT_MASK_EN
        bif.pat_mask_in = mski;
`endif
        hit = 1'b0;
        if (!r) begin
            m_pat  = 4'b1011;
            m_mask = 4'b1111;
            m_cnt  = 2'd0;
            mq.delete();
        end else begin
            if (ld) begin
                m_pat = pi;
`ifdef SEQ_DETECT_MASK_EN
                m_mask = mski;
`endif
                mq.delete();
            end else if (v) begin
                mq.push_back(xb);
                if (mq.size() > 4) void'(mq.pop_front());
                if (mq.size() == 4) begin
                    w = {mq[0], mq[1], mq[2], mq[3]};
                    hit = ((w ^ m_pat) & m_mask) == 4'b0000;
                end
                if (hit && !ovl) mq.delete();
            end
            if (clr) m_cnt = 2'd0;
            else if (hit && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
        e.f     = hit;
        e.cnt   = m_cnt;
        e.armed = (mq.size() == 4);
        sb.push_back(e);
    endtask

    task automatic bit_in(input logic b);
        step(1'b1, 1'b1, b, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b1, 1'b0, i[0], 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic load(input logic [3:0] p);
        step(1'b1, 1'b0, 1'b0, 1'b1, p, 1'b1);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        int f0;
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0);
        settle();
        checks++;
        if (bif.F !== 1'b0 || bif.match_cnt !== 2'd0 || bif.armed !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got F=%b cnt=%0d armed=%b required 0 0 0",
                     bif.F, bif.match_cnt, bif.armed);
        end
        f0 = f_seen;
        ovl = 1'b1;
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        idle(2);
        settle();
        checks++;
        if (f_seen - f0 !== 1 || bif.match_cnt !== 2'd1) begin
            errors++;
            $display("FAIL reset_pat pulses=%0d cnt=%0d required 1 1",
                     f_seen - f0, bif.match_cnt);
        end
    endtask

    task automatic test_overlap();
        int f0;
        ovl = 1'b1;
        load(4'b1010);
        f0 = f_seen;
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        idle(2);
        settle();
        checks++;
        if (f_seen - f0 !== 2 || bif.match_cnt !== 2'd2) begin
            errors++;
            $display("FAIL overlap_on pulses=%0d cnt=%0d required 2 2",
                     f_seen - f0, bif.match_cnt);
        end
        ovl = 1'b0;
        load(4'b1010);
        f0 = f_seen;
        bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1); bit_in(0);
        idle(2);
        settle();
        checks++;
        if (f_seen - f0 !== 1 || bif.match_cnt !== 2'd1) begin
            errors++;
            $display("FAIL overlap_off pulses=%0d cnt=%0d required 1 1",
                     f_seen - f0, bif.match_cnt);
        end
        ovl = 1'b1;
    endtask

    task automatic test_gaps();
        int f0;
        load(4'b1011);
        f0 = f_seen;
        bit_in(1); bit_in(0);
        idle(5);
        bit_in(1); bit_in(1);
        idle(1);
        settle();
        checks++;
        if (f_seen - f0 !== 1 || bif.match_cnt !== 2'd1) begin
            errors++;
            $display("FAIL gaps pulses=%0d cnt=%0d required 1 1",
                     f_seen - f0, bif.match_cnt);
        end
    endtask

    task automatic test_saturation();
        load(4'b1011);
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        for (int i = 0; i < 4; i++) begin
            bit_in(0); bit_in(1); bit_in(1);
        end
        idle(1);
        settle();
        checks++;
        if (bif.match_cnt !== 2'd3) begin
            errors++;
            $display("FAIL saturate cnt=%0d required 3", bif.match_cnt);
        end
        bit_in(0); bit_in(1);
        step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1);
        settle();
        checks++;
        if (bif.F !== 1'b1 || bif.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clr_vs_hit got F=%b cnt=%0d required 1 0",
                     bif.F, bif.match_cnt);
        end
        idle(1);
    endtask

    task automatic test_load_mid();
        int f0;
        load(4'b1011);
        bit_in(1); bit_in(0); bit_in(1);
        f0 = f_seen;
        step(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 1'b0);
        settle();
        checks++;
        if (bif.F !== 1'b0 || bif.armed !== 1'b0) begin
            errors++;
            $display("FAIL load_drop got F=%b armed=%b required 0 0",
                     bif.F, bif.armed);
        end
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        idle(1);
        settle();
        checks++;
        if (f_seen - f0 !== 1) begin
            errors++;
            $display("FAIL load_after pulses=%0d required 1", f_seen - f0);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        bit_in(1); bit_in(0); bit_in(1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        f0 = f_seen;
        bit_in(1);
        settle();
        checks++;
        if (f_seen - f0 !== 0 || bif.match_cnt !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid pulses=%0d cnt=%0d required 0 0",
                     f_seen - f0, bif.match_cnt);
        end
        bit_in(1); bit_in(0); bit_in(1); bit_in(1);
        idle(1);
        settle();
        checks++;
        if (f_seen - f0 !== 1 || bif.match_cnt !== 2'd1) begin
            errors++;
            $display("FAIL reset_refill pulses=%0d cnt=%0d required 1 1",
                     f_seen - f0, bif.match_cnt);
        end
    endtask

`ifdef SEQ_DETECT_MASK_EN
    task automatic test_mask();
        int f0;
        mski = 4'b1101;
        load(4'b1011);
        f0 = f_seen;
        bit_in(1); bit_in(1); bit_in(1); bit_in(1);
        idle(1);
        settle();
        checks++;
        if (f_seen - f0 !== 1) begin
            errors++;
            $display("FAIL mask pulses=%0d required 1", f_seen - f0);
        end
        mski = 4'b1111;
    endtask
`endif

    initial begin
        bif.x        = 1'b0;
        bif.x_valid  = 1'b0;
        bif.overlap  = 1'b1;
        bif.pat_load = 1'b0;
        bif.pat_in   = 4'b0000;
        bif.cnt_clr  = 1'b0;
`ifdef SEQ_DETECT_MASK_EN
        bif.pat_mask_in = 4'b1111;
`endif
        test_reset();
        test_overlap();
        test_gaps();
        test_saturation();
        test_load_mid();
        test_reset_mid();
`ifdef SEQ_DETECT_MASK_EN
        test_mask();
`endif
        idle(1);
        settle();
        settle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial sequence detector; the configurable successor to the team's fixed 3-bit hand-encoded Moore detector.
- Samples a qualified 1-bit stream and compares it against a runtime-loadable PAT_W-bit pattern.
- Emits a registered one-cycle match pulse on F and keeps a saturating match count.
- Overlapping and non-overlapping detection are selectable at runtime.

Parameters:
PAT_W, 4, pattern length in bits; legal range 2..16.
CNT_W, 8, width of the match counter.
RESET_PAT, 4'b1011, pattern loaded at reset; zero-extended or truncated to PAT_W.

Ports:
clk  input  1  clock; all state updates on the rising edge.
rst  input  1  reset, synchronous, active-low; sampled on the rising edge of clk.
x  input  1  serial data bit.
x_valid  input  1  x is sampled only in cycles where this is 1.
overlap  input  1  1 = overlapping detection; 0 = non-overlapping.
pat_load  input  1  load pat_in as the new pattern.
pat_in  input  PAT_W  new pattern; MSB is the first (oldest) bit of the sequence.
cnt_clr  input  1  clear match_cnt.
F  output  1  match pulse, registered.
match_cnt  output  CNT_W  saturating count of matches.
armed  output  1  1 when fill == PAT_W, i.e. history fully populated.

Behaviour:
- Reset (rst==0 at a clk edge):
  - pat = RESET_PAT; hist = 0; fill = 0; F = 0; match_cnt = 0; armed = 0.
  - rst low without a clock edge has no effect.
  - Reset overrides every other input in that cycle.
- State:
  - hist: PAT_W-bit shift register of accepted samples; newest bit at LSB.
  - fill: counter 0..PAT_W of samples accepted since the last reset, pattern load or non-overlap match.
  - pat: current pattern register.
- Sample accept (x_valid=1, pat_load=0):
  - cand = {hist[PAT_W-2:0], x}; hist <= cand.
  - fill <= min(fill+1, PAT_W).
  - Hit when (fill+1 >= PAT_W) and (cand == pat).
- Latency:
  - F = 1 in the cycle following the accepting edge, for exactly one cycle.
  - F = 0 in every other cycle, including idle x_valid=0 cycles.
- Overlap handling on a hit:
  - overlap=1: hist and fill are retained, so a suffix of the match may start the next match.
  - overlap=0: fill <= 0 and hist <= 0; the next match needs PAT_W fresh samples.
  - overlap is sampled per accepted bit; changing it mid-stream affects only subsequent hits.
- pat_load=1:
  - pat <= pat_in; hist <= 0; fill <= 0; F <= 0.
  - pat_load wins over a same-cycle x_valid; that sample is dropped and no hit is evaluated.
- Counter:
  - match_cnt increments by 1 per hit and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 sets match_cnt <= 0.
  - cnt_clr wins over a same-cycle hit; that hit is not counted, but F still pulses.
- armed = (fill == PAT_W), registered.
- Gaps: x_valid=0 cycles leave hist, fill and pat unchanged; detection spans gaps of any length.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- When defined:
  - Adds port pat_mask_in (input, PAT_W bits), captured into a pat_mask register on pat_load; reset value is all ones.
  - Hit condition becomes ((cand ^ pat) & pat_mask) == 0; mask bits = 0 are don't-care.
  - The fill requirement is unchanged.
- When undefined: the port and register are absent and comparison is exact equality.

Test Plan:
1. Reset: drive rst=0 for 2 edges with x_valid=1, x=1 -> F=0, match_cnt=0, armed=0; then feed RESET_PAT bits 1,0,1,1 -> F=1 one cycle after the 4th bit, match_cnt=1.
2. Overlap: load pat_in=4'b1010, overlap=1, stream 1,0,1,0,1,0 -> F pulses after samples 4 and 6, match_cnt=2. Repeat with overlap=0 -> F pulses after sample 4 only, match_cnt=1.
3. Gaps: pattern 1011, bits 1,0 then x_valid=0 for 5 cycles with x toggling, then bits 1,1 -> exactly one F pulse, after the last bit.
4. Saturation and clear: CNT_W=2, produce 5 matches -> match_cnt stays 3. cnt_clr asserted in the same cycle as a hit -> match_cnt=0 and F=1.
5. Load mid-stream: pattern 1011, feed 1,0,1, then pat_load=1 with pat_in=4'b1011 and x_valid=1, x=1 in the same cycle -> no F, fill=0; next 1,0,1,1 -> F once.
6. Reset mid-match: after 1,0,1 assert rst=0 for one edge, then feed 1 -> no F; a full 1,0,1,1 -> F. With SEQ_DETECT_MASK_EN, pat=1011, mask=4'b1101, stream 1,1,1,1 -> F=1.
